// File: rtl/axi_pkg.sv
// Shared AXI encodings and read-side state type used by the SRAM slaves.
`timescale 1ns/1ps
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_4B     = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next word address for FIXED/INCR/WRAP bursts.
`timescale 1ns/1ps
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;
  logic              wrap_ok;

  assign incr_addr = addr + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign wrap_mask = {{(ADDR_W-4){1'b0}}, len};
  // Only power-of-two lengths form a legal wrap window; anything else degrades to INCR.
  assign wrap_ok   = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);

  always_comb begin
    next_addr = incr_addr;
    unique case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = wrap_ok ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask))
                                       : incr_addr;
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_sram_read_slave.sv
// AXI4 read-only slave in front of a single-port synchronous SRAM; one burst in flight,
// 2-cycle initial latency, then one beat per cycle under RREADY.
`timescale 1ns/1ps
module axi_sram_read_slave
  import axi_pkg::*;
#(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   ARID,
  input  logic [31:0]       ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  input  logic [DATA_W-1:0] sram_do
);

  rd_state_e         state_reg;
  logic [ID_W-1:0]   id_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [3:0]        len_reg;
  logic [3:0]        cnt_reg;
  logic [1:0]        burst_reg;
  logic              err_reg;
  logic [ADDR_W-1:0] addr_next;
  logic              beat_hs;
  logic              unused_araddr;

  assign unused_araddr = ^{ARADDR[31:ADDR_W+2], ARADDR[1:0]};

  axi_burst_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .addr      (addr_reg),
    .len       (len_reg),
    .burst     (burst_reg),
    .next_addr (addr_next)
  );

  // Gating with ARESETn keeps ARREADY low while reset is held even though state is IDLE.
  assign ARREADY  = (state_reg == IDLE) && ARESETn;
  assign RVALID   = (state_reg == DATA);
  assign RLAST    = RVALID && (cnt_reg == len_reg);
  assign RID      = id_reg;
  assign RRESP    = (RVALID && err_reg) ? RESP_SLVERR : RESP_OKAY;
  assign RDATA    = (RVALID && !err_reg) ? sram_do : '0;
  assign beat_hs  = RVALID && RREADY;

  // Fetch the next word in the handshake cycle so beats stream without a bubble;
  // during a stall the current word is re-read, keeping sram_do stable.
  assign sram_a   = (beat_hs && !RLAST) ? addr_next : addr_reg;
  assign sram_ceb = (state_reg == IDLE) ? 1'b1 : err_reg;
  assign sram_web = 1'b1;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg <= IDLE;
      id_reg    <= '0;
      addr_reg  <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
      burst_reg <= BURST_INCR;
      err_reg   <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (ARVALID) begin
            id_reg    <= ARID;
            addr_reg  <= ARADDR[ADDR_W+1:2];
            len_reg   <= ARLEN;
            burst_reg <= ARBURST;
            err_reg   <= (ARSIZE != SIZE_4B);
            cnt_reg   <= '0;
            state_reg <= ADDR;
          end
        end
        ADDR: state_reg <= DATA;
        DATA: begin
          if (RREADY) begin
            if (cnt_reg == len_reg) begin
              state_reg <= IDLE;
            end else begin
              cnt_reg  <= cnt_reg + 4'd1;
              addr_reg <= addr_next;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_read_slave.sv
// Directed plus randomized burst bench for axi_sram_read_slave against a modular-arithmetic
// address model and a behavioural SRAM.
`timescale 1ns/1ps
module tb_axi_sram_read_slave;

  localparam int ID_W   = 8;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              ACLK = 1'b0;
  logic              ARESETn;
  logic [ID_W-1:0]   ARID;
  logic [31:0]       ARADDR;
  logic [3:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;
  logic              sram_ceb;
  logic              sram_web;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_do;

  logic [31:0] mem [DEPTH];
  int n_cmp = 0;
  int n_err = 0;

  axi_sram_read_slave #(
    .ID_W   (ID_W),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .ARID     (ARID),
    .ARADDR   (ARADDR),
    .ARLEN    (ARLEN),
    .ARSIZE   (ARSIZE),
    .ARBURST  (ARBURST),
    .ARVALID  (ARVALID),
    .ARREADY  (ARREADY),
    .RID      (RID),
    .RDATA    (RDATA),
    .RRESP    (RRESP),
    .RLAST    (RLAST),
    .RVALID   (RVALID),
    .RREADY   (RREADY),
    .sram_ceb (sram_ceb),
    .sram_web (sram_web),
    .sram_a   (sram_a),
    .sram_do  (sram_do)
  );

  always #5 ACLK = ~ACLK;

  // Synchronous SRAM: data appears the cycle after the address is sampled.
  always @(posedge ACLK) begin
    if (!sram_ceb) sram_do <= mem[sram_a];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word address of beat i, from the burst rules expressed as plain window arithmetic.
  function automatic int ref_addr(input int start, input int len, input logic [1:0] burst,
                                  input int i);
    int n;
    n = len + 1;
    if (burst == 2'b00) return start;
    if (burst == 2'b10 && (n == 2 || n == 4 || n == 8 || n == 16))
      return (start / n) * n + ((start % n) + i) % n;
    return (start + i) % DEPTH;
  endfunction

  // mode 0: RREADY always high; 1: 3-cycle stall on beat 1; 2: random stalls.
  // abort_beat >= 0 asserts reset while that beat is on the bus.
  task automatic run_burst(input logic [7:0] id, input logic [31:0] araddr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode,
                           input int abort_beat);
    int start;
    int i;
    int stall;
    int cycles;
    int ea;
    logic err;
    logic rr;
    start  = int'(araddr[ADDR_W+1:2]);
    err    = (size != 3'b010);
    i      = 0;
    stall  = 0;
    cycles = 0;
    @(negedge ACLK);
    ARID = id; ARADDR = araddr; ARLEN = len[3:0]; ARSIZE = size; ARBURST = burst;
    ARVALID = 1'b1; RREADY = 1'b0;
    #1 chk("arready_idle", ARREADY, 1'b1);
    @(posedge ACLK);
    @(negedge ACLK);
    ARVALID = 1'b0;
    chk("arready_n1", ARREADY, 1'b0);
    chk("rvalid_n1", RVALID, 1'b0);
    chk("sram_a_n1", sram_a, ref_addr(start, len, burst, 0));
    chk("ceb_n1", sram_ceb, err);
    while (i <= len && cycles < 200) begin
      @(negedge ACLK);
      cycles++;
      ea = ref_addr(start, len, burst, i);
      chk("rvalid", RVALID, 1'b1);
      chk("rdata", RDATA, err ? 32'h0 : mem[ea]);
      chk("rresp", RRESP, err ? 2'b10 : 2'b00);
      chk("rid", RID, id);
      chk("rlast", RLAST, i == len);
      chk("ceb", sram_ceb, err);
      chk("arready_busy", ARREADY, 1'b0);
      if (i == abort_beat) begin
        ARESETn = 1'b0;
        #1;
        chk("rst_rvalid", RVALID, 1'b0);
        chk("rst_ceb", sram_ceb, 1'b1);
        chk("rst_arready", ARREADY, 1'b0);
        chk("rst_rlast", RLAST, 1'b0);
        chk("rst_rresp", RRESP, 2'b00);
        chk("rst_rid", RID, 8'h00);
        RREADY = 1'b0;
        $display("burst id=%h addr=%h len=%0d burst=%0d reset at beat %0d",
                 id, araddr, len, burst, i);
        return;
      end
      if (mode == 1) rr = !(i == 1 && stall < 3);
      else if (mode == 2) rr = ($urandom_range(0, 9) >= 3);
      else rr = 1'b1;
      if (!rr) stall++;
      RREADY = rr;
      #1 chk("sram_a", sram_a, (rr && i < len) ? ref_addr(start, len, burst, i + 1) : ea);
      @(posedge ACLK);
      if (rr) i++;
    end
    chk("beat_count", i, len + 1);
    @(negedge ACLK);
    RREADY = 1'b0;
    chk("rvalid_after", RVALID, 1'b0);
    chk("arready_after", ARREADY, 1'b1);
    $display("burst id=%h addr=%h len=%0d burst=%0d size=%0d beats=%0d stalls=%0d",
             id, araddr, len, burst, size, i, stall);
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
    ARESETn = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'b010;
    ARBURST = 2'b01; ARVALID = 1'b0; RREADY = 1'b0;
    #1;
    chk("reset_arready", ARREADY, 1'b0);
    chk("reset_rvalid", RVALID, 1'b0);
    chk("reset_rlast", RLAST, 1'b0);
    chk("reset_rresp", RRESP, 2'b00);
    chk("reset_rid", RID, 8'h00);
    chk("reset_ceb", sram_ceb, 1'b1);
    chk("web_tied", sram_web, 1'b1);
    repeat (3) @(negedge ACLK);
    ARESETn = 1'b1;
    #1 chk("release_arready", ARREADY, 1'b1);

    run_burst(8'h21, 32'h0000_0010, 0, 3'b010, 2'b01, 0, -1);
    run_burst(8'h05, 32'h0000_0040, 3, 3'b010, 2'b01, 0, -1);
    run_burst(8'h06, 32'h0000_0040, 3, 3'b010, 2'b01, 1, -1);
    run_burst(8'h07, 32'h0000_0018, 3, 3'b010, 2'b10, 0, -1);
    run_burst(8'h08, 32'h0000_0024, 2, 3'b010, 2'b00, 0, -1);
    run_burst(8'h09, 32'h0000_0100, 1, 3'b001, 2'b01, 0, -1);
    run_burst(8'h0c, 32'h0000_0018, 2, 3'b010, 2'b10, 0, -1);
    run_burst(8'h0d, (DEPTH - 2) * 4, 3, 3'b010, 2'b01, 0, -1);
    run_burst(8'h0e, 32'h0000_003c, 15, 3'b010, 2'b10, 2, -1);

    run_burst(8'h0a, 32'h0000_0040, 3, 3'b010, 2'b01, 0, 1);
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    #1 chk("rerelease_arready", ARREADY, 1'b1);
    run_burst(8'h0b, 32'h0000_0000, 0, 3'b010, 2'b01, 0, -1);

    for (int t = 0; t < 25; t++) begin
      run_burst(8'($urandom), $urandom, int'($urandom_range(0, 15)),
                ($urandom_range(0, 9) == 0) ? 3'b011 : 3'b010,
                2'($urandom_range(0, 2)), 2, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
